// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, enables and
// the fetch state encoding.
package if_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0] ZeroWord  = 32'h0000_0000;
    localparam logic               Enable    = 1'b1;
    localparam logic               Disable   = 1'b0;
    localparam logic               RstEnable = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fetch_state_e;

    // Branch targets are word aligned; the low two bits are ignored.
    function automatic logic [InstAddrBus-1:0] align4(input logic [InstAddrBus-1:0] a);
        return {a[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: assembles each 32-bit instruction from four little-endian
// byte beats and holds it for IF/ID until the pipeline accepts it.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_i,
    output logic                   mem_req,
    output logic [InstAddrBus-1:0] mem_addr,
    input  logic                   mem_ack,
    input  logic [7:0]             mem_rdata,
    output logic [InstAddrBus-1:0] if_pc,
    output logic [InstBus-1:0]     if_inst,
    output logic                   stallreq_o,
    output logic [1:0]             dbg_state_o
);

    // Handshake: a beat is requested while mem_req=1 with mem_addr held
    // constant; it completes in the cycle mem_ack=1, which may be the very
    // first cycle of the request. IF/ID takes the word on a DONE cycle edge
    // with stall[1]=0.

    fetch_state_e           state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [1:0]             beat_q, beat_d;
    logic [23:0]            buf_q, buf_d;
    logic [InstBus-1:0]     inst_q, inst_d;
    logic                   redir_pend_q, redir_pend_d;
    logic [InstAddrBus-1:0] redir_pc_q, redir_pc_d;
    logic                   started_q, started_d;
    logic [InstAddrBus-1:0] target;

    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5:2], stall[0]};

    assign target = align4(branch_target_i);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        beat_d       = beat_q;
        buf_d        = buf_q;
        inst_d       = inst_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        started_d    = started_q;

        case (state_q)
            IDLE: begin
                // One settling cycle after reset release before the first request.
                started_d = Enable;
                if (branch_flag_i) begin
                    pc_d    = target;
                    beat_d  = 2'd0;
                    state_d = FETCH;
                end else if (started_q) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (mem_ack) begin
                    if (branch_flag_i) begin
                        pc_d         = target;
                        beat_d       = 2'd0;
                        redir_pend_d = Disable;
                    end else if (redir_pend_q) begin
                        pc_d         = redir_pc_q;
                        beat_d       = 2'd0;
                        redir_pend_d = Disable;
                    end else begin
                        case (beat_q)
                            2'd0: buf_d[7:0]   = mem_rdata;
                            2'd1: buf_d[15:8]  = mem_rdata;
                            2'd2: buf_d[23:16] = mem_rdata;
                            default: begin
                                inst_d  = {mem_rdata, buf_q};
                                state_d = DONE;
                            end
                        endcase
                        beat_d = beat_q + 2'd1;
                    end
                end else if (branch_flag_i) begin
                    // Beat in flight: finish it, then drop the byte and redirect.
                    redir_pend_d = Enable;
                    redir_pc_d   = target;
                end
            end

            DONE: begin
                if (branch_flag_i) begin
                    pc_d    = target;
                    beat_d  = 2'd0;
                    state_d = FETCH;
                end else if (!stall[1]) begin
                    pc_d    = pc_q + 32'd4;
                    beat_d  = 2'd0;
                    state_d = FETCH;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            beat_q       <= 2'd0;
            buf_q        <= 24'd0;
            inst_q       <= ZeroWord;
            redir_pend_q <= Disable;
            redir_pc_q   <= '0;
            started_q    <= Disable;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            beat_q       <= beat_d;
            buf_q        <= buf_d;
            inst_q       <= inst_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
            started_q    <= started_d;
        end
    end

    assign mem_req     = (state_q == FETCH);
    assign mem_addr    = (state_q == FETCH) ? (pc_q + {30'd0, beat_q}) : '0;
    assign if_pc       = (state_q == DONE) ? pc_q : '0;
    assign if_inst     = (state_q == DONE) ? inst_q : ZeroWord;
    assign stallreq_o  = (state_q != DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus random stall,
// branch and memory wait states against a transaction-level model.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_o;
  logic [1:0]  dbg_state_o;

  int n_cmp;
  int n_bad;
  int wait_mode;
  logic [31:0] exp_q[$];

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .if_pc(if_pc), .if_inst(if_inst),
    .stallreq_o(stallreq_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory contents ----------------
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0: return 8'h13;
      32'h1: return 8'h05;
      32'h2: return 8'h10;
      32'h3: return 8'h00;
      default: return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'ha5;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder (drives at negedge) ----------------
  int resp_cnt;
  int resp_need;
  always @(negedge clk) begin
    if (!rst) begin
      mem_ack  = 1'b0;
      resp_cnt = 0;
    end else if (mem_req) begin
      if (resp_cnt == 0) resp_need = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
      if (resp_cnt >= resp_need) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_byte(mem_addr);
        resp_cnt  = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom_range(0, 255);
        resp_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      resp_cnt = 0;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  // m_phase: 0 just out of reset, 1 ready to start, 2 collecting bytes, 3 word held
  int          m_phase;
  logic [31:0] m_pc;
  int          m_n;
  logic        m_pend;
  logic [31:0] m_ptgt;
  logic        p_valid, p_req, p_ack;
  logic [31:0] p_addr;

  always @(negedge clk) begin
    #3;
    if (!rst) begin
      m_phase = 0; m_pc = 32'h0; m_n = 0; m_pend = 1'b0;
      p_valid = 1'b0;
    end else begin
      logic [31:0] tgt;
      tgt = {branch_target_i[31:2], 2'b00};
      chk("stallreq", stallreq_o, (m_phase != 3));
      chk("mem_req", mem_req, (m_phase == 2));
      chk("mem_addr", mem_addr, (m_phase == 2) ? m_pc + 32'(m_n) : 32'h0);
      chk("if_pc", if_pc, (m_phase == 3) ? m_pc : 32'h0);
      chk("if_inst", if_inst, (m_phase == 3) ? mem_word(m_pc) : 32'h0);
      if (p_valid && p_req && !p_ack) begin
        chk("req_stable", mem_req, 1'b1);
        chk("addr_stable", mem_addr, p_addr);
      end
      case (m_phase)
        0, 1: begin
          if (branch_flag_i) begin m_pc = tgt; m_n = 0; m_phase = 2; end
          else m_phase = m_phase + 1;
        end
        2: begin
          if (mem_ack) begin
            if (branch_flag_i) begin m_pc = tgt; m_n = 0; m_pend = 1'b0; end
            else if (m_pend) begin m_pc = m_ptgt; m_n = 0; m_pend = 1'b0; end
            else begin m_n++; if (m_n == 4) m_phase = 3; end
          end else if (branch_flag_i) begin
            m_pend = 1'b1; m_ptgt = tgt;
          end
        end
        default: begin
          if (branch_flag_i) begin m_pc = tgt; m_n = 0; m_phase = 2; end
          else if (!stall[1]) begin
            exp_q.push_back(mem_word(m_pc));
            chk("handoff_inst", if_inst, exp_q.pop_front());
            m_pc = m_pc + 32'd4; m_n = 0; m_phase = 2;
          end
        end
      endcase
      p_valid = 1'b1; p_req = mem_req; p_ack = mem_ack; p_addr = mem_addr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 300 && stallreq_o; k++) step();
    if (stallreq_o) chk("wait_done_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_unacked(input logic [31:0] a);
    int k;
    for (k = 0; k < 300 && !(mem_req && !mem_ack && mem_addr == a); k++) step();
    if (!(mem_req && !mem_ack && mem_addr == a)) chk("wait_addr_timeout", mem_addr, a);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] ack_addr[4];
    logic [31:0] h_pc, h_inst;
    int na;
    n_cmp = 0; n_bad = 0;
    rst = 1'b0; stall = 6'b0; branch_flag_i = 1'b0; branch_target_i = 32'h0;
    mem_ack = 1'b0; mem_rdata = 8'h0; wait_mode = 0;

    // reset values
    step(); step();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_stallreq", stallreq_o, 1'b1);
    rst = 1'b1;
    step();
    chk("first_edge_no_req", mem_req, 1'b0);
    step();
    chk("second_edge_req", mem_req, 1'b1);
    chk("second_edge_addr", mem_addr, 32'h0);

    // zero-wait fetch: 4 FETCH cycles then DONE
    step(); step(); step(); step();
    chk("zw_stallreq", stallreq_o, 1'b0);
    chk("zw_inst", if_inst, 32'h0010_0513);
    chk("zw_pc", if_pc, 32'h0);
    step();
    chk("zw_next_addr", mem_addr, 32'h4);

    // wait states on the fetch at 0x8
    wait_done();
    wait_mode = 3;
    step();
    na = 0;
    for (int k = 0; k < 100 && stallreq_o; k++) begin
      if (mem_req && mem_ack && na < 4) begin ack_addr[na] = mem_addr; na++; end
      step();
    end
    chk("ws_ack_count", na, 4);
    for (int i = 0; i < 4; i++) chk("ws_ack_addr", ack_addr[i], 32'h8 + i);
    chk("ws_pc", if_pc, 32'h8);

    // downstream stall holds the word
    stall = 6'b000011;
    h_pc = if_pc; h_inst = if_inst;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_pc_hold", if_pc, h_pc);
      chk("stall_inst_hold", if_inst, h_inst);
      chk("stall_no_req", mem_req, 1'b0);
    end
    stall = 6'b0;
    step();
    chk("stall_release_addr", mem_addr, 32'hC);

    // branch while beat 2 is pending
    wait_unacked(32'hE);
    branch_flag_i = 1'b1; branch_target_i = 32'h100;
    step();
    branch_flag_i = 1'b0; branch_target_i = 32'h0;
    for (int k = 0; k < 50 && mem_addr == 32'hE; k++) step();
    chk("br_restart_addr", mem_addr, 32'h100);
    wait_done();
    chk("br_pc", if_pc, 32'h100);
    chk("br_inst", if_inst, mem_word(32'h100));

    // branch from DONE despite stall, unaligned target, address wrap
    stall = 6'b000011;
    branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFE;
    step();
    branch_flag_i = 1'b0;
    chk("wrap_first_addr", mem_addr, 32'hFFFF_FFFC);
    stall = 6'b0;
    wait_mode = 0;
    wait_done();
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_next_addr", mem_addr, 32'h0);

    // asynchronous reset in the middle of beat 1
    wait_mode = 3;
    wait_unacked(32'h1);
    rst = 1'b0;
    #1;
    chk("arst_mem_req", mem_req, 1'b0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    chk("arst_stallreq", stallreq_o, 1'b1);
    chk("arst_if_inst", if_inst, 32'h0);
    wait_mode = 0;
    step();
    rst = 1'b1;
    step(); step();
    chk("arst_restart_addr", mem_addr, 32'h0);
    chk("arst_restart_req", mem_req, 1'b1);

    // random traffic
    wait_mode = -1;
    for (int i = 0; i < 1500; i++) begin
      stall = 6'($urandom);
      stall[1] = ($urandom_range(0, 9) < 3);
      branch_flag_i = ($urandom_range(0, 24) == 0);
      branch_target_i = $urandom;
      step();
    end
    branch_flag_i = 1'b0; stall = 6'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
